// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the two-entry skid pipeline register.
package pipe_skid_reg_pkg;

   // Occupancy is reported directly from the state encoding.
   localparam int OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_skid_reg_data_reg_en.sv
// N-bit data register with synchronous reset value and load enable.
module data_reg_en #(
   parameter int          N       = 32,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Reset wins over load; otherwise hold unless enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register. The main register drives out_data; the
// skid register catches one extra word when the consumer stalls, so in_ready
// depends only on registered state (plus flush) and never on out_ready.
//
// Handshake: a transfer happens on a side when its valid and ready are both 1
// at posedge clk. out_valid is registered; the only combinational
// input-to-output path is flush -> in_ready.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int           N          = 32,
   parameter logic [N-1:0] RST_VAL    = '0,
   parameter logic [N-1:0] BUBBLE_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   occupancy
);

   state_t       state;
   state_t       state_nxt;
   logic         in_xfer;
   logic         out_xfer;
   logic         main_en;
   logic [N-1:0] main_d;
   logic         skid_en;
   logic [N-1:0] skid_q;

   assign in_ready  = (state != TWO) & ~flush;
   assign out_valid = (state != EMPTY);
   assign occupancy = state;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   // State register; reset has priority over flush and transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and register load controls.
   always_comb begin
      state_nxt = state;
      main_en   = 1'b0;
      main_d    = in_data;
      skid_en   = 1'b0;
      if (flush) begin
         // Skid content is simply abandoned; the bubble goes into main.
         state_nxt = EMPTY;
         main_en   = 1'b1;
         main_d    = BUBBLE_VAL;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state_nxt = ONE;
                  main_en   = 1'b1;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_en = 1'b1;
               end else if (in_xfer) begin
                  state_nxt = TWO;
                  skid_en   = 1'b1;
               end else if (out_xfer) begin
                  // main keeps its last value on draining to empty
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  state_nxt = ONE;
                  main_en   = 1'b1;
                  main_d    = skid_q;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   data_reg_en #(.N(N), .RST_VAL(RST_VAL)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (out_data)
   );

   data_reg_en #(.N(N), .RST_VAL(RST_VAL)) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (in_data),
      .q   (skid_q)
   );

endmodule
